// File: rtl/jcpu_pkg.sv
// Shared types and constants for the jcscpu clock/stepper slice.
// Quarter-phase and stepper-state enums, step-bus reset pattern and
// small decode helpers used by clk_stepper and jphase_gen.
package jcpu_pkg;

  localparam int NSTEPS = 6;

  // One-hot step bus, index 0 is step 0 (leftmost bit of the literal).
  localparam logic [0:NSTEPS-1] STP_RESET = 6'b100000;

  typedef enum logic [1:0] {Q0, Q1, Q2, Q3} phase_t;

  typedef enum logic [1:0] {IDLE, RUN, HALTED, PAUSE} stpst_t;

  // The four clock-like outputs, in output-port order.
  typedef struct packed {
    logic clk;
    logic clkd;
    logic clke;
    logic clks;
  } qclk_t;

  localparam qclk_t QCLK_OFF = '{clk: 1'b0, clkd: 1'b0, clke: 1'b0, clks: 1'b0};

  // Quarter phase -> clock levels. clke = clk|clkd, clks = clk&clkd.
  function automatic qclk_t phase_decode(phase_t q);
    qclk_t c;
    c = QCLK_OFF;
    case (q)
      Q0: begin c.clk = 1'b1; c.clke = 1'b1; end
      Q1: begin c.clk = 1'b1; c.clkd = 1'b1; c.clke = 1'b1; c.clks = 1'b1; end
      Q2: begin c.clkd = 1'b1; c.clke = 1'b1; end
      default: c = QCLK_OFF;
    endcase
    return c;
  endfunction

  // Q0 -> Q1 -> Q2 -> Q3 -> Q0.
  function automatic phase_t phase_next(phase_t q);
    phase_t n;
    case (q)
      Q0: n = Q1;
      Q1: n = Q2;
      Q2: n = Q3;
      default: n = Q0;
    endcase
    return n;
  endfunction

  // Advance the one-hot step: bit k moves to bit k+1, last bit wraps to 0.
  function automatic logic [0:NSTEPS-1] stp_rotate(logic [0:NSTEPS-1] s);
    return {s[NSTEPS-1], s[0:NSTEPS-2]};
  endfunction

endpackage

// File: rtl/jphase_gen.sv
// Quarter-phase generator: DIV-cycle divider plus Q0..Q3 counter.
// The stepper tells it whether the current cycle is a RUN cycle (adv) and
// whether the next one will be (run_nx); outside RUN everything is held at 0.
// Outputs are flops loaded from the next-state decode, so the clock-like
// outputs never glitch. q3_end is high during the final cycle of Q3;
// q3_end_nx is its next-state value for the stepper's own output flops.
module jphase_gen import jcpu_pkg::*; #(
  parameter int DIV = 4
) (
  input  logic CLK_sys,
  input  logic RST_n,
  input  logic adv,
  input  logic run_nx,
  output logic CLK_clk,
  output logic CLK_clkd,
  output logic CLK_clke,
  output logic CLK_clks,
  output logic q3_end,
  output logic q3_end_nx
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  phase_t phase, phase_nx;
  logic   last;     // current cycle is the last of its quarter
  logic   last_nx;  // next cycle will be the last of its quarter
  qclk_t  ck_nx;

  generate
    if (DIV == 1) begin : g_nodiv
      // Divider bypassed: every cycle is a whole quarter.
      assign last    = 1'b1;
      assign last_nx = 1'b1;
    end else begin : g_div
      logic [CW-1:0] cnt, cnt_nx;

      // Divider count: runs only across consecutive RUN cycles, else 0.
      always_comb begin
        cnt_nx = '0;
        if (run_nx && adv && !last) cnt_nx = cnt + CW'(1);
      end

      assign last    = (cnt == CW'(DIV - 1));
      assign last_nx = (cnt_nx == CW'(DIV - 1));

      // Divider register.
      always_ff @(posedge CLK_sys or negedge RST_n) begin
        if (!RST_n) cnt <= '0;
        else        cnt <= cnt_nx;
      end
    end
  endgenerate

  // Next phase: entering RUN (from IDLE/HALTED/PAUSE) always starts at Q0.
  always_comb begin
    phase_nx = Q0;
    if (run_nx && adv) phase_nx = last ? phase_next(phase) : phase;
    ck_nx     = run_nx ? phase_decode(phase_nx) : QCLK_OFF;
    q3_end_nx = run_nx && (phase_nx == Q3) && last_nx;
  end

  // Phase register and registered clock outputs.
  always_ff @(posedge CLK_sys or negedge RST_n) begin
    if (!RST_n) begin
      phase    <= Q0;
      CLK_clk  <= 1'b0;
      CLK_clkd <= 1'b0;
      CLK_clke <= 1'b0;
      CLK_clks <= 1'b0;
      q3_end   <= 1'b0;
    end else begin
      phase    <= phase_nx;
      CLK_clk  <= ck_nx.clk;
      CLK_clkd <= ck_nx.clkd;
      CLK_clke <= ck_nx.clke;
      CLK_clks <= ck_nx.clks;
      q3_end   <= q3_end_nx;
    end
  end

endmodule

// File: rtl/clk_stepper.sv
// Clock-phase generator and 6-step stepper for the jcscpu core.
// Produces CLK_clk/clkd/clke/clks via jphase_gen and the one-hot STP_bus.
// A halt request is latched (halt_pend) and honoured only at the end of
// step 5 Q3, so instructions always finish cleanly.
// Optional feature macro STEP_SINGLE_EN adds ss_mode/step_req ports and the
// PAUSE state (stop after every step until step_req).
module clk_stepper import jcpu_pkg::*; #(
  parameter int DIV = 4
) (
  input  logic              CLK_sys,
  input  logic              RST_n,
  input  logic              start,
  input  logic              halt_req,
`ifdef STEP_SINGLE_EN
  input  logic              ss_mode,
  input  logic              step_req,
`endif
  output logic              CLK_clk,
  output logic              CLK_clkd,
  output logic              CLK_clke,
  output logic              CLK_clks,
  output logic [0:NSTEPS-1] STP_bus,
  output logic              running,
  output logic              instr_done
);

  stpst_t            state, state_nx;
  logic [0:NSTEPS-1] stp_nx;
  logic              halt_pend, pend_nx;
  logic              q3_end, q3_end_nx;
  logic              run_nx;

  assign run_nx = (state_nx == RUN);

  jphase_gen #(.DIV(DIV)) u_phase (
    .CLK_sys   (CLK_sys),
    .RST_n     (RST_n),
    .adv       (state == RUN),
    .run_nx    (run_nx),
    .CLK_clk   (CLK_clk),
    .CLK_clkd  (CLK_clkd),
    .CLK_clke  (CLK_clke),
    .CLK_clks  (CLK_clks),
    .q3_end    (q3_end),
    .q3_end_nx (q3_end_nx)
  );

  // Stepper next state, step bus and halt latch.
  always_comb begin
    state_nx = state;
    stp_nx   = STP_bus;
    pend_nx  = halt_pend;
    case (state)
      IDLE, HALTED: begin
        stp_nx = STP_RESET;
        if (start) state_nx = RUN;
      end
      RUN: begin
        // Same-cycle request still counts at this boundary.
        pend_nx = halt_pend | halt_req;
        if (q3_end) begin
          if (STP_bus[NSTEPS-1] && pend_nx) begin
            state_nx = HALTED;
            stp_nx   = STP_RESET;
            pend_nx  = 1'b0;
          end else begin
            stp_nx = stp_rotate(STP_bus);
`ifdef STEP_SINGLE_EN
            if (ss_mode) state_nx = PAUSE;
`endif
          end
        end
      end
`ifdef STEP_SINGLE_EN
      PAUSE: begin
        // STP_bus already shows the step about to run.
        if (step_req) state_nx = RUN;
      end
`endif
      default: begin
        state_nx = IDLE;
        stp_nx   = STP_RESET;
        pend_nx  = 1'b0;
      end
    endcase
  end

  // State, step bus and status flops, all loaded from next-state values.
  always_ff @(posedge CLK_sys or negedge RST_n) begin
    if (!RST_n) begin
      state      <= IDLE;
      STP_bus    <= STP_RESET;
      halt_pend  <= 1'b0;
      running    <= 1'b0;
      instr_done <= 1'b0;
    end else begin
      state      <= state_nx;
      STP_bus    <= stp_nx;
      halt_pend  <= pend_nx;
      running    <= (state_nx == RUN) || (state_nx == PAUSE);
      instr_done <= q3_end_nx && stp_nx[NSTEPS-1];
    end
  end

endmodule

// File: tb/tb_clk_stepper.sv
// Scoreboard bench for clk_stepper: DUT A (DIV=2) for start/halt/reset and
// single-step cases, DUT B (DIV=1) for free-running instructions.
// Stimulus pushes expected per-cycle output vectors into a queue; a negedge
// monitor pops and compares whenever an entry is due.
module tb_clk_stepper;

  typedef struct {
    int         at;
    logic [0:5] stp;
    logic [3:0] ck;   // {clk, clkd, clke, clks}
    logic       run;
    logic       done;
  } exp_t;

  logic CLK_sys = 1'b0;
  logic RST_n   = 1'b1;
  logic start_a = 1'b0, halt_a = 1'b0, start_b = 1'b0, halt_b = 1'b0;
`ifdef STEP_SINGLE_EN
  logic ss_a = 1'b0, sreq_a = 1'b0;
`endif
  logic a_clk, a_clkd, a_clke, a_clks, a_run, a_done;
  logic b_clk, b_clkd, b_clke, b_clks, b_run, b_done;
  logic [0:5] a_stp, b_stp;

  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t qa[$];
  exp_t qb[$];

  always #5 CLK_sys = ~CLK_sys;
  always @(posedge CLK_sys) cyc <= cyc + 1;

  clk_stepper #(.DIV(2)) dut_a (
    .CLK_sys(CLK_sys), .RST_n(RST_n), .start(start_a), .halt_req(halt_a),
`ifdef STEP_SINGLE_EN
    .ss_mode(ss_a), .step_req(sreq_a),
`endif
    .CLK_clk(a_clk), .CLK_clkd(a_clkd), .CLK_clke(a_clke), .CLK_clks(a_clks),
    .STP_bus(a_stp), .running(a_run), .instr_done(a_done)
  );

  clk_stepper #(.DIV(1)) dut_b (
    .CLK_sys(CLK_sys), .RST_n(RST_n), .start(start_b), .halt_req(halt_b),
`ifdef STEP_SINGLE_EN
    .ss_mode(1'b0), .step_req(1'b0),
`endif
    .CLK_clk(b_clk), .CLK_clkd(b_clkd), .CLK_clke(b_clke), .CLK_clks(b_clks),
    .STP_bus(b_stp), .running(b_run), .instr_done(b_done)
  );

  // Quarter phase -> {clk, clkd, clke, clks}
  function automatic logic [3:0] qck(int q);
    case (q)
      0: return 4'b1010;
      1: return 4'b1111;
      2: return 4'b0110;
      default: return 4'b0000;
    endcase
  endfunction

  // Expected outputs in the j-th RUN cycle after start (j = 1 first).
  function automatic exp_t e_run(int at, int div, int j);
    exp_t e;
    int pos, st, q;
    logic [0:5] one;
    one    = 6'b100000;
    pos    = (j - 1) % (24 * div);
    st     = pos / (4 * div);
    q      = (pos % (4 * div)) / div;
    e.at   = at;
    e.stp  = one >> st;
    e.ck   = qck(q);
    e.run  = 1'b1;
    e.done = (st == 5) && ((pos % (4 * div)) == 4 * div - 1);
    return e;
  endfunction

  function automatic exp_t e_idle(int at);
    exp_t e;
    e.at = at; e.stp = 6'b100000; e.ck = 4'b0000; e.run = 1'b0; e.done = 1'b0;
    return e;
  endfunction

  function automatic exp_t e_pause(int at, int st);
    exp_t e;
    logic [0:5] one;
    one = 6'b100000;
    e.at = at; e.stp = one >> st; e.ck = 4'b0000; e.run = 1'b1; e.done = 1'b0;
    return e;
  endfunction

  task automatic push_run_a(int base, int jlo, int jhi);
    for (int j = jlo; j <= jhi; j++) qa.push_back(e_run(base + j, 2, j));
  endtask

  task automatic push_idle_a(int lo, int hi);
    for (int c = lo; c <= hi; c++) qa.push_back(e_idle(c));
  endtask

  task automatic tick;
    @(posedge CLK_sys);
    #1;
  endtask

  task automatic goto(int n);
    while (cyc < n) tick();
  endtask

  task automatic cmp(string tag, exp_t e, logic [0:5] stp, logic [3:0] ck,
                     logic run, logic done);
    n_tests++;
    if (stp !== e.stp || ck !== e.ck || run !== e.run || done !== e.done) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got stp=%b ck=%b run=%b done=%b expected stp=%b ck=%b run=%b done=%b",
               tag, e.at, stp, ck, run, done, e.stp, e.ck, e.run, e.done);
    end
  endtask

  // Monitor: compare every due scoreboard entry on the falling edge.
  always @(negedge CLK_sys) begin
    exp_t e;
    while (qa.size() > 0 && qa[0].at <= cyc) begin
      e = qa.pop_front();
      if (e.at < cyc) begin
        n_tests++; n_fail++;
        $display("FAIL dutA_missed entry at=%0d now=%0d", e.at, cyc);
      end else
        cmp("dutA", e, a_stp, {a_clk, a_clkd, a_clke, a_clks}, a_run, a_done);
    end
    while (qb.size() > 0 && qb[0].at <= cyc) begin
      e = qb.pop_front();
      if (e.at < cyc) begin
        n_tests++; n_fail++;
        $display("FAIL dutB_missed entry at=%0d now=%0d", e.at, cyc);
      end else
        cmp("dutB", e, b_stp, {b_clk, b_clkd, b_clke, b_clks}, b_run, b_done);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset values while reset is held and after release.
    #1 RST_n = 1'b0;
    qa.push_back(e_idle(2));
    qb.push_back(e_idle(2));
    goto(3);
    RST_n = 1'b1;
    qa.push_back(e_idle(5));
    qb.push_back(e_idle(5));

    // DUT B, DIV=1: three instructions plus a wrap, instr_done every 24.
    goto(5);
    start_b = 1'b1;
    for (int j = 1; j <= 75; j++) qb.push_back(e_run(5 + j, 1, j));
    qa.push_back(e_idle(10));   // A must stay idle without its own start
    goto(6);
    start_b = 1'b0;

    // T1 (A, DIV=2): halt pulse in step 2, stray start during RUN.
    goto(85);
    start_a = 1'b1;
    push_run_a(85, 1, 48);
    push_idle_a(134, 140);
    goto(86);  start_a = 1'b0;
    goto(105); halt_a  = 1'b1;
    goto(106); halt_a  = 1'b0;
    goto(115); start_a = 1'b1;
    goto(116); start_a = 1'b0;

    // T2: resume from HALTED; halt_req only in the final Q3 cycle.
    goto(145);
    start_a = 1'b1;
    push_run_a(145, 1, 48);
    push_idle_a(194, 197);
    goto(146); start_a = 1'b0;
    goto(193); halt_a  = 1'b1;
    goto(194); halt_a  = 1'b0;

    // T3: request just after the boundary waits a full instruction.
    goto(200);
    start_a = 1'b1;
    push_run_a(200, 1, 96);
    push_idle_a(297, 300);
    goto(201); start_a = 1'b0;
    goto(249); halt_a  = 1'b1;
    goto(250); halt_a  = 1'b0;

    // T4: asynchronous reset during step 3 Q1, then a fresh start.
    goto(305);
    start_a = 1'b1;
    push_run_a(305, 1, 26);
    goto(306); start_a = 1'b0;
    goto(332);
    push_idle_a(332, 333);
    qb.push_back(e_idle(332));
    qb.push_back(e_idle(333));
    RST_n = 1'b0;
    goto(334);
    RST_n = 1'b1;
    goto(336);
    start_a = 1'b1;
    push_run_a(336, 1, 9);
    goto(337); start_a = 1'b0;

`ifdef STEP_SINGLE_EN
    // T5: single-step mode; pause after step 0, hold 50 cycles, one step.
    goto(350);
    ss_a    = 1'b1;
    start_a = 1'b1;
    push_run_a(350, 1, 8);
    for (int c = 359; c <= 408; c++) qa.push_back(e_pause(c, 1));
    goto(351); start_a = 1'b0;
    goto(408);
    sreq_a = 1'b1;
    for (int j = 59; j <= 66; j++) qa.push_back(e_run(350 + j, 2, j - 50));
    for (int c = 417; c <= 420; c++) qa.push_back(e_pause(c, 2));
    goto(409); sreq_a = 1'b0;
    goto(425);
`else
    goto(350);
`endif

    if (qa.size() != 0 || qb.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL leftover entries qa=%0d qb=%0d expected 0", qa.size(), qb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
